// File: rtl/inst_mem_loader.sv
// Instruction memory write-side loader: unpacks a length-prefixed byte stream into
// 32-bit words and issues one write per word while holding the pipeline in stall.
module inst_mem_loader #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          BYTES = DATA_W / 8;
    localparam int          BC_W  = $clog2(BYTES);
    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]          lane_q [BYTES-1];
    logic [7:0]          lane_d [BYTES-1];
    logic                rx_ready_q, rx_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                xfer;
    logic                last_byte;
    logic                last_word;
    logic                n_bad;
    logic [15:0]         n_new;
    logic [CNT_W-1:0]    word_cnt_inc;
    logic [DATA_W-1:0]   word_full;

    assign xfer         = rx_valid & rx_ready_q;
    assign last_byte    = (byte_cnt_q == BC_W'(BYTES - 1));
    assign word_cnt_inc = word_cnt_q + 1'b1;
    assign last_word    = (16'(word_cnt_inc) == n_q);
    assign n_new        = {n_q[15:8], rx_data};
    assign n_bad        = (n_new == 16'd0) || (n_new > MAX_N);

    // Lanes hold the first BYTES-1 bytes of a word; the final byte is taken straight
    // from rx_data so the write can issue on the cycle after the 4th transfer.
    generate
        for (genvar gi = 0; gi < BYTES - 1; gi++) begin : g_lane
            assign lane_d[gi] = (state_q == S_DATA && xfer && byte_cnt_q == BC_W'(gi))
                                ? rx_data : lane_q[gi];
            assign word_full[DATA_W-1-8*gi -: 8] = lane_q[gi];
        end
    endgenerate
    assign word_full[7:0] = rx_data;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_ready_d = rx_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_CNT_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    rx_ready_d = 1'b1;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    n_d[15:8] = rx_data;
                    state_d   = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    n_d = n_new;
                    if (n_bad) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        busy_d     = 1'b0;
                        rx_ready_d = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (last_byte) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = word_full;
                        word_cnt_d = word_cnt_inc;
                        byte_cnt_d = '0;
                        // Closing the frame here drops rx_ready together with the
                        // final write, so trailing bytes are never consumed.
                        if (last_word) begin
                            state_d    = S_DONE;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            rx_ready_d = 1'b0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                rx_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            lane_q     <= '{default: '0};
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            lane_q     <= lane_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: frames are streamed byte by byte and every
// memory write is logged with its cycle number for address/data/spacing checks.
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ready_waits = 0;
    int cyc = 0;

    logic [10:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    inst_mem_loader dut (
        .clock    (clk),
        .reset    (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger: samples just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 20) begin
            ready_waits++;
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_byte_ready: rx_ready=%b after %0d cycles, required 1", rx_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({rx_ready, wr_en, busy, done, error} !== 5'b00000)
            $display("FAIL reset_flags: rdy/wr/busy/done/err=%b, required 00000",
                     {rx_ready, wr_en, busy, done, error});
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 11'd0 || wr_data !== 32'd0)
            $display("FAIL reset_wr_bus: addr=%h data=%h, required 000 00000000", wr_addr, wr_data);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({rx_ready, busy} !== 2'b00)
            $display("FAIL idle_no_start: rdy/busy=%b, required 00", {rx_ready, busy});
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        do_reset();
        pulse_start();
        total_cnt++;
        if ({busy, rx_ready, done, error} !== 4'b1100)
            $display("FAIL start_flags: busy/rdy/done/err=%b, required 1100", {busy, rx_ready, done, error});
        else pass_cnt++;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        rx_valid = 1'b0;
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 32'hDEADBEEF)
            $display("FAIL single_write: wr_en=%b addr=%h data=%h, required 1 000 deadbeef",
                     wr_en, wr_addr, wr_data);
        else pass_cnt++;
        total_cnt++;
        if ({done, busy, rx_ready} !== 3'b100)
            $display("FAIL single_done_same_cycle: done/busy/rdy=%b, required 100", {done, busy, rx_ready});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_en !== 1'b0 || done !== 1'b1 || wr_data !== 32'hDEADBEEF)
            $display("FAIL single_after: wr_en=%b done=%b data=%h, required 0 1 deadbeef",
                     wr_en, done, wr_data);
        else pass_cnt++;
        total_cnt++;
        if (wq_addr.size() != 1)
            $display("FAIL single_write_count: writes=%0d, required 1", wq_addr.size());
        else pass_cnt++;
        $display("test_single_word done");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  frame [14];
        logic [31:0] exp_w [3];
        frame = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        exp_w = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        do_reset();
        pulse_start();
        ready_waits = 0;
        for (int i = 0; i < 14; i++) send_byte(frame[i]);
        rx_valid = 1'b0;
        total_cnt++;
        if (ready_waits != 0)
            $display("FAIL b2b_ready_drop: stall cycles=%0d, required 0", ready_waits);
        else pass_cnt++;
        total_cnt++;
        if (wq_addr.size() != 3)
            $display("FAIL b2b_write_count: writes=%0d, required 3", wq_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            total_cnt++;
            if (wq_addr[i] !== 11'(i) || wq_data[i] !== exp_w[i])
                $display("FAIL b2b_word%0d: addr=%h data=%h, required %h %h",
                         i, wq_addr[i], wq_data[i], 11'(i), exp_w[i]);
            else pass_cnt++;
        end
        for (int i = 1; i < 3 && i < wq_cyc.size(); i++) begin
            total_cnt++;
            if (wq_cyc[i] - wq_cyc[i-1] != 4)
                $display("FAIL b2b_spacing%0d: gap=%0d cycles, required 4", i, wq_cyc[i] - wq_cyc[i-1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b_done: done=%b busy=%b, required 1 0", done, busy);
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_bad_count();
        do_reset();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b0;
        total_cnt++;
        if ({error, busy, rx_ready, done} !== 4'b1000)
            $display("FAIL n0_error: err/busy/rdy/done=%b, required 1000", {error, busy, rx_ready, done});
        else pass_cnt++;
        pulse_start();
        total_cnt++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL n0_restart: error=%b busy=%b, required 0 1", error, busy);
        else pass_cnt++;
        send_byte(8'h08);
        send_byte(8'h01);
        rx_valid = 1'b0;
        total_cnt++;
        if ({error, busy, rx_ready} !== 3'b100)
            $display("FAIL n2049_error: err/busy/rdy=%b, required 100", {error, busy, rx_ready});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wq_addr.size() != 0 || error !== 1'b1)
            $display("FAIL bad_no_write: writes=%0d error=%b, required 0 1", wq_addr.size(), error);
        else pass_cnt++;
        pulse_start();
        total_cnt++;
        if (error !== 1'b0)
            $display("FAIL n2049_restart: error=%b, required 0", error);
        else pass_cnt++;
        $display("test_bad_count done");
    endtask

    task automatic test_full_memory();
        logic [31:0] w;
        int          bad;
        do_reset();
        pulse_start();
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            w = {i[7:0], i[15:8] ^ 8'h5A, 8'hC3, ~i[7:0]};
            for (int k = 0; k < 4; k++) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(w[31-8*k -: 8]);
            end
        end
        rx_valid = 1'b0;
        total_cnt++;
        if (wq_addr.size() != 2048)
            $display("FAIL full_write_count: writes=%0d, required 2048", wq_addr.size());
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++) begin
            w = {i[7:0], i[15:8] ^ 8'h5A, 8'hC3, ~i[7:0]};
            total_cnt++;
            if (wq_addr[i] !== 11'(i) || wq_data[i] !== w) begin
                if (bad < 8)
                    $display("FAIL full_word%0d: addr=%h data=%h, required %h %h",
                             i, wq_addr[i], wq_data[i], 11'(i), w);
                bad++;
            end else pass_cnt++;
        end
        total_cnt++;
        if (wr_addr !== 11'h7FF || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL full_last: addr=%h done=%b busy=%b, required 7ff 1 0", wr_addr, done, busy);
        else pass_cnt++;
        $display("test_full_memory done (word errors %0d)", bad);
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
        send_byte(8'h12);
        send_byte(8'h34);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rx_ready, wr_en, busy, done, error} !== 5'b00000)
            $display("FAIL midrst_flags: rdy/wr/busy/done/err=%b, required 00000",
                     {rx_ready, wr_en, busy, done, error});
        else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 11'd0 || wr_data !== 32'd0)
            $display("FAIL midrst_wr_bus: addr=%h data=%h, required 000 00000000", wr_addr, wr_data);
        else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wq_addr.size() != 1)
            $display("FAIL midrst_write_count: writes=%0d, required 1", wq_addr.size());
        else pass_cnt++;
        if (wq_addr.size() > 0) begin
            total_cnt++;
            if (wq_addr[0] !== 11'd0 || wq_data[0] !== 32'hCAFEF00D)
                $display("FAIL midrst_word0: addr=%h data=%h, required 000 cafef00d", wq_addr[0], wq_data[0]);
            else pass_cnt++;
        end
        $display("test_reset_mid_load done");
    endtask

    task automatic test_start_mid_data();
        do_reset();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        pulse_start();
        total_cnt++;
        if ({busy, rx_ready, done} !== 3'b110)
            $display("FAIL midstart_flags: busy/rdy/done=%b, required 110", {busy, rx_ready, done});
        else pass_cnt++;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        total_cnt++;
        if (done !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 11'd1)
            $display("FAIL midstart_done: done=%b wr_en=%b addr=%h, required 1 1 001", done, wr_en, wr_addr);
        else pass_cnt++;
        rx_data = 8'hFF;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (rx_ready !== 1'b0 || wr_en !== 1'b0)
                $display("FAIL extra_byte%0d: rdy=%b wr_en=%b, required 0 0", i, rx_ready, wr_en);
            else pass_cnt++;
        end
        rx_valid = 1'b0;
        total_cnt++;
        if (wq_addr.size() != 2)
            $display("FAIL midstart_write_count: writes=%0d, required 2", wq_addr.size());
        else pass_cnt++;
        if (wq_addr.size() >= 2) begin
            total_cnt++;
            if (wq_data[0] !== 32'h11223344 || wq_data[1] !== 32'h55667788 || wq_addr[1] !== 11'd1)
                $display("FAIL midstart_data: d0=%h d1=%h a1=%h, required 11223344 55667788 001",
                         wq_data[0], wq_data[1], wq_addr[1]);
            else pass_cnt++;
        end
        $display("test_start_mid_data done");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_count();
        test_full_memory();
        test_reset_mid_load();
        test_start_mid_data();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
